gate_bist: RTL and testbench
============================

// Module: gate_bist
// PURPOSE
//   Hardware self-test sequencer for an N-input single-output logic gate.
//   Drives every input vector 0..2^N_IN-1 onto the gate under test and compares F_IN against a golden model.
//   The golden model is AND/OR/XOR/NAND, selected at run time.
//   Counts mismatches and captures the first failing vector. Replaces per-gate open-coded truth-table benches.
// PARAMETERS
//   N_IN        2   number of gate inputs / vector width (1..8)
//   SETTLE_CYC  1   cycles between driving a vector and sampling F_IN (0..15)
// PORTS
//   CLK       in   1        clock, rising edge
//   RST       in   1        synchronous reset, active-high
//   START     in   1        run request; sampled only in IDLE or DONE
//   OP        in   2        golden op: 00 AND, 01 OR, 10 XOR, 11 NAND; latched when START accepted
//   A_OUT     out  N_IN     vector driven to gate under test (registered)
//   F_IN      in   1        gate-under-test output
//   BUSY      out  1        high from DRIVE of vector 0 through last CHECK
//   DONE      out  1        high while in DONE state
//   PASS      out  1        valid when DONE=1: 1 iff ERR_CNT==0
//   ERR_CNT   out  N_IN+1   mismatch count, 0..2^N_IN (cannot overflow)
//   FAIL_VEC  out  N_IN     first mismatching vector; 0 if none
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high. RST=1 at any edge overrides all other inputs.
//     It returns the FSM to IDLE and zeroes A_OUT, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC, vector counter, settle counter and latched OP.
//   - FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
//   - IDLE:   START=1 -> latch OP; clear ERR_CNT, FAIL_VEC, PASS, first-fail flag; vec=0 -> DRIVE.
//   - DRIVE:  A_OUT<=vec for 1 cycle.
//             Goes to SETTLE if SETTLE_CYC>0, otherwise straight to CHECK.
//   - SETTLE: stays exactly SETTLE_CYC cycles -> CHECK.
//   - CHECK:  1 cycle. Compares F_IN with golden(A_OUT, OP_latched).
//             On mismatch: ERR_CNT+=1, and FAIL_VEC<=A_OUT if this is the first mismatch of the run.
//             If vec==2^N_IN-1 -> DONE; else vec+=1 -> DRIVE.
//             Vector counter is N_IN+1 bits so the terminal test never wraps.
//   - DONE:   DONE=1, BUSY=0. PASS<=(ERR_CNT==0) is registered on entry.
//             ERR_CNT, FAIL_VEC and A_OUT hold.
//             START=1 restarts as from IDLE: next state is DRIVE, results cleared, new OP latched.
//   - Golden model: AND=&A, OR=|A, XOR=^A, NAND=~&A, computed over all N_IN bits.
//   - START while BUSY is ignored. OP changes after acceptance are ignored.
//   - Timing: START sampled at edge 0.
//     DRIVE of vector k occurs in cycle 1+k*(SETTLE_CYC+2).
//     CHECK of vector k occurs in cycle (k+1)*(SETTLE_CYC+2).
//     DONE=1 from cycle 2^N_IN*(SETTLE_CYC+2)+1.
//   - F_IN is sampled only in CHECK; values in other states have no effect.
//   - Reset mid-run: results are discarded and no partial DONE is produced.
// TESTING (N_IN=2, SETTLE_CYC=1 unless stated; DONE expected at cycle 13)
//   1. F_IN=&A_OUT, OP=00, START pulse
//      -> A_OUT steps 00,01,10,11; DONE=1 @13; PASS=1; ERR_CNT=0; FAIL_VEC=00.
//   2. F_IN stuck at 0, OP=00
//      -> ERR_CNT=1; FAIL_VEC=11; PASS=0.
//   3. F_IN=&A_OUT, OP=10 (XOR)
//      -> mismatches at 01, 10, 11; ERR_CNT=3; FAIL_VEC=01; PASS=0.
//   4. RST=1 at cycle 7, then START again
//      -> all outputs 0 the cycle after RST; second run completes cleanly with DONE @13 relative to the new START.
//   5. START held high through the run, then pulsed in DONE with OP=01 and F_IN=|A_OUT
//      -> first run is unaffected; second run clears ERR_CNT and ends with PASS=1.
//   6. N_IN=3, SETTLE_CYC=0, OP=11, F_IN stuck at 1
//      -> DONE @17; ERR_CNT=1; FAIL_VEC=111.

Source files
------------

// File: rtl/gate_bist.sv
// ---------------------------------------------------------------------------
// gate_bist
//   Self-test sequencer for an N_IN-input, single-output logic gate. Walks
//   every input vector 0..2^N_IN-1 onto the gate under test, waits SETTLE_CYC
//   cycles, then compares the gate output against a run-time selectable
//   golden function (AND / OR / XOR / NAND). Counts mismatches and keeps the
//   first failing vector.
//
// Parameters
//   N_IN        gate input count / vector width (1..8)
//   SETTLE_CYC  cycles between driving a vector and sampling i_fIn (0..15)
//
// Ports
//   i_clk      clock, rising edge
//   i_rst      synchronous reset, active-high
//   i_start    run request, honoured only when idle or done
//   i_op       golden op: 00 AND, 01 OR, 10 XOR, 11 NAND (latched on start)
//   o_aOut     vector driven to the gate under test (registered)
//   i_fIn      gate-under-test output
//   o_busy     high from the first DRIVE through the last CHECK
//   o_done     high while the sequencer sits in DONE
//   o_pass     valid with o_done: 1 when no mismatches were seen
//   o_errCnt   mismatch count, 0..2^N_IN
//   o_failVec  first mismatching vector, 0 if none
// ---------------------------------------------------------------------------
module gate_bist #(
  parameter int N_IN       = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  output logic [N_IN-1:0] o_aOut,
  input  logic            i_fIn,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [N_IN:0]   o_errCnt,
  output logic [N_IN-1:0] o_failVec
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // The vector counter carries one spare bit so the terminal compare against
  // 2^N_IN-1 is made before any increment could wrap it.
  localparam logic [N_IN:0] LAST_VEC    = {1'b0, {N_IN{1'b1}}};
  localparam logic [3:0]    SETTLE_LAST = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;

  state_t          r_state;
  logic [1:0]      r_op;
  logic [N_IN:0]   r_vec;
  logic [3:0]      r_settle;
  logic            r_firstSeen;
  logic [N_IN-1:0] r_aOut;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [N_IN:0]   r_errCnt;
  logic [N_IN-1:0] r_failVec;

  logic            w_golden;
  logic            w_mismatch;
  logic [N_IN:0]   w_errNext;

  // Golden model evaluated on the vector currently presented to the gate,
  // so it always lines up with what i_fIn is reacting to in CHECK.
  always_comb begin
    w_golden = 1'b0;
    case (r_op)
      2'b00:   w_golden = &r_aOut;
      2'b01:   w_golden = |r_aOut;
      2'b10:   w_golden = ^r_aOut;
      default: w_golden = ~&r_aOut;
    endcase
  end

  assign w_mismatch = (i_fIn != w_golden);
  assign w_errNext  = r_errCnt + {{N_IN{1'b0}}, w_mismatch};

  // Main sequencer. PASS is taken from the post-CHECK count so a mismatch on
  // the final vector is reflected in the verdict registered on DONE entry.
  // A start request is only looked at in IDLE and DONE, which is what makes
  // START-while-busy harmless.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_op        <= 2'b00;
      r_vec       <= '0;
      r_settle    <= 4'd0;
      r_firstSeen <= 1'b0;
      r_aOut      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_errCnt    <= '0;
      r_failVec   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_op        <= i_op;
            r_errCnt    <= '0;
            r_failVec   <= '0;
            r_pass      <= 1'b0;
            r_firstSeen <= 1'b0;
            r_vec       <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_aOut   <= r_vec[N_IN-1:0];
          r_settle <= 4'd0;
          r_state  <= (SETTLE_CYC > 0) ? ST_SETTLE : ST_CHECK;
        end
        ST_SETTLE: begin
          if (r_settle == SETTLE_LAST) begin
            r_state <= ST_CHECK;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            r_errCnt <= w_errNext;
            if (!r_firstSeen) begin
              r_failVec   <= r_aOut;
              r_firstSeen <= 1'b1;
            end
          end
          if (r_vec == LAST_VEC) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_errNext == '0);
            r_state <= ST_DONE;
          end else begin
            r_vec   <= r_vec + 1'b1;
            r_state <= ST_DRIVE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_aOut    = r_aOut;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_pass    = r_pass;
  assign o_errCnt  = r_errCnt;
  assign o_failVec = r_failVec;

endmodule

// File: tb/tb_gate_bist.sv
// ---------------------------------------------------------------------------
// tb_gate_bist
//   Directed bench for gate_bist. Two instances: a 2-input gate with one
//   settle cycle and a 3-input gate with no settle cycles. The gate under
//   test is modelled by a selectable behaviour (true AND, true OR, stuck-0,
//   stuck-1). Expected vector order and end-of-run results are pushed to
//   queues when a run is launched and popped as the DUT reaches each point.
// ---------------------------------------------------------------------------
module tb_gate_bist;

  typedef struct {
    int errCnt;
    int failVec;
    int pass;
  } result_t;

  localparam int F_AND    = 0;
  localparam int F_STUCK0 = 1;
  localparam int F_STUCK1 = 2;
  localparam int F_OR     = 3;

  logic       clk;
  logic       rst;
  logic       start2;
  logic       start3;
  logic [1:0] op;
  int         fMode;

  logic [1:0] aOut2;
  logic       fIn2;
  logic       busy2;
  logic       done2;
  logic       pass2;
  logic [2:0] errCnt2;
  logic [1:0] failVec2;

  logic [2:0] aOut3;
  logic       fIn3;
  logic       busy3;
  logic       done3;
  logic       pass3;
  logic [3:0] errCnt3;
  logic [2:0] failVec3;

  int errors = 0;
  int checks = 0;

  int      expVecQ[$];
  result_t expResQ[$];

  gate_bist #(.N_IN(2), .SETTLE_CYC(1)) dut2 (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start2),
    .i_op      (op),
    .o_aOut    (aOut2),
    .i_fIn     (fIn2),
    .o_busy    (busy2),
    .o_done    (done2),
    .o_pass    (pass2),
    .o_errCnt  (errCnt2),
    .o_failVec (failVec2)
  );

  gate_bist #(.N_IN(3), .SETTLE_CYC(0)) dut3 (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start3),
    .i_op      (op),
    .o_aOut    (aOut3),
    .i_fIn     (fIn3),
    .o_busy    (busy3),
    .o_done    (done3),
    .o_pass    (pass3),
    .o_errCnt  (errCnt3),
    .o_failVec (failVec3)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behaviour of the gate under test for a given vector.
  function automatic logic modelF(input int mode, input logic [7:0] a, input int n);
    logic andV;
    logic orV;
    andV = 1'b1;
    orV  = 1'b0;
    for (int i = 0; i < n; i++) begin
      andV = andV & a[i];
      orV  = orV | a[i];
    end
    case (mode)
      F_AND:    return andV;
      F_STUCK0: return 1'b0;
      F_STUCK1: return 1'b1;
      default:  return orV;
    endcase
  endfunction

  // Reference golden function the sequencer is expected to apply.
  function automatic logic goldenF(input int opSel, input int a, input int n);
    int ones;
    ones = 0;
    for (int i = 0; i < n; i++) ones += (a >> i) & 1;
    case (opSel)
      0:       return (ones == n);
      1:       return (ones != 0);
      2:       return ones[0];
      default: return (ones != n);
    endcase
  endfunction

  // The gate under test reacts combinationally to the driven vector.
  assign fIn2 = modelF(fMode, 8'(aOut2), 2);
  assign fIn3 = modelF(fMode, 8'(aOut3), 3);

  function automatic logic [31:0] getAOut(input int sel);
    return (sel != 0) ? 32'(aOut3) : 32'(aOut2);
  endfunction
  function automatic logic [31:0] getBusy(input int sel);
    return (sel != 0) ? 32'(busy3) : 32'(busy2);
  endfunction
  function automatic logic [31:0] getDone(input int sel);
    return (sel != 0) ? 32'(done3) : 32'(done2);
  endfunction
  function automatic logic [31:0] getPass(input int sel);
    return (sel != 0) ? 32'(pass3) : 32'(pass2);
  endfunction
  function automatic logic [31:0] getErrCnt(input int sel);
    return (sel != 0) ? 32'(errCnt3) : 32'(errCnt2);
  endfunction
  function automatic logic [31:0] getFailVec(input int sel);
    return (sel != 0) ? 32'(failVec3) : 32'(failVec2);
  endfunction

  // Single comparison point: counts it, and on a miss reports and counts it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input int sel, input string tag);
    checkOutput({tag, ".aOut"},    getAOut(sel),    32'd0);
    checkOutput({tag, ".busy"},    getBusy(sel),    32'd0);
    checkOutput({tag, ".done"},    getDone(sel),    32'd0);
    checkOutput({tag, ".pass"},    getPass(sel),    32'd0);
    checkOutput({tag, ".errCnt"},  getErrCnt(sel),  32'd0);
    checkOutput({tag, ".failVec"}, getFailVec(sel), 32'd0);
  endtask

  task automatic setStart(input int sel, input logic v);
    if (sel != 0) start3 = v;
    else          start2 = v;
  endtask

  // Launches one run and follows it to DONE. Expected results are derived
  // from the bench models and queued before the start pulse is applied.
  // With holdStart, START stays high through the run and OP is scrambled
  // mid-run; both must be ignored.
  task automatic applyStimulus(input string tag, input int sel, input int opSel,
                               input int mode, input int holdStart);
    int      n;
    int      period;
    int      doneCyc;
    int      k;
    result_t r;
    bit      firstSeen;
    n         = (sel != 0) ? 3 : 2;
    period    = (sel != 0) ? 2 : 3;
    doneCyc   = (1 << n) * period + 1;
    r.errCnt  = 0;
    r.failVec = 0;
    firstSeen = 1'b0;
    for (int v = 0; v < (1 << n); v++) begin
      expVecQ.push_back(v);
      if (modelF(mode, 8'(v), n) != goldenF(opSel, v, n)) begin
        r.errCnt++;
        if (!firstSeen) begin
          r.failVec = v;
          firstSeen = 1'b1;
        end
      end
    end
    r.pass = (r.errCnt == 0) ? 1 : 0;
    expResQ.push_back(r);

    @(negedge clk);
    fMode = mode;
    op    = 2'(opSel);
    setStart(sel, 1'b1);
    @(posedge clk);
    for (int c = 1; c <= doneCyc; c++) begin
      @(negedge clk);
      if (holdStart == 0 || c == doneCyc - 1) setStart(sel, 1'b0);
      if (holdStart != 0 && c == 2) op = ~op;
      if (c == 1) begin
        checkOutput($sformatf("%s.c1.errCnt", tag),  getErrCnt(sel),  32'd0);
        checkOutput($sformatf("%s.c1.failVec", tag), getFailVec(sel), 32'd0);
        checkOutput($sformatf("%s.c1.pass", tag),    getPass(sel),    32'd0);
      end
      if (c % period == 0) begin
        k = expVecQ.pop_front();
        checkOutput($sformatf("%s.vec%0d", tag, k), getAOut(sel), 32'(k));
      end
      if (c < doneCyc) begin
        checkOutput($sformatf("%s.c%0d.busy", tag, c), getBusy(sel), 32'd1);
        checkOutput($sformatf("%s.c%0d.done", tag, c), getDone(sel), 32'd0);
      end else begin
        r = expResQ.pop_front();
        checkOutput($sformatf("%s.end.done", tag),    getDone(sel),    32'd1);
        checkOutput($sformatf("%s.end.busy", tag),    getBusy(sel),    32'd0);
        checkOutput($sformatf("%s.end.pass", tag),    getPass(sel),    32'(r.pass));
        checkOutput($sformatf("%s.end.errCnt", tag),  getErrCnt(sel),  32'(r.errCnt));
        checkOutput($sformatf("%s.end.failVec", tag), getFailVec(sel), 32'(r.failVec));
      end
    end
    setStart(sel, 1'b0);
  endtask

  initial begin
    rst    = 1'b1;
    start2 = 1'b0;
    start3 = 1'b0;
    op     = 2'b00;
    fMode  = F_AND;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero(0, "reset2");
    checkAllZero(1, "reset3");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle2.done", getDone(0), 32'd0);

    $display("[TB] run 1: true AND gate, OP=AND");
    applyStimulus("t1", 0, 0, F_AND, 0);

    $display("[TB] run 2: stuck-at-0 gate, OP=AND");
    applyStimulus("t2", 0, 0, F_STUCK0, 0);

    $display("[TB] run 3: AND gate checked against XOR");
    applyStimulus("t3", 0, 2, F_AND, 0);

    $display("[TB] run 4: reset in cycle 7, then a clean run");
    @(negedge clk);
    op     = 2'b10;
    fMode  = F_STUCK0;
    start2 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start2 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkAllZero(0, "t4.afterRst");
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t4.noDone%0d", c), getDone(0), 32'd0);
    end
    applyStimulus("t4", 0, 0, F_AND, 0);

    $display("[TB] run 5: START held through the run, then restart with OR");
    applyStimulus("t5a", 0, 0, F_AND, 1);
    applyStimulus("t5b", 0, 1, F_OR, 0);

    $display("[TB] run 6: 3-input, no settle, stuck-at-1 against NAND");
    applyStimulus("t6", 1, 3, F_STUCK1, 0);

    checkOutput("scoreboardEmpty", 32'(expVecQ.size() + expResQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
